k12a_sram_seq: RTL
==================

// Module: k12a_sram_seq
// PURPOSE
//   Sequences CPU memory requests onto an external asynchronous SRAM on sys_clock.
//   It sits downstream of the clock controller, in the sys_clock domain.
//   It accepts one request at a time over a valid/ready handshake and drives glitch-free
//   registered chip-enable, output-enable, write-enable and data-direction strobes.
//   The setup and strobe lengths are programmable.
//   Read data is returned with a one-cycle response pulse.
// PARAMETERS
//   ADDR_WIDTH    16  SRAM address width
//   DATA_WIDTH     8  SRAM data width
//   SETUP_CYCLES   1  cycles of address/data setup before strobe; legal range >=1
//   WAIT_STATES    2  cycles the strobe is held active; legal range >=1
// PORTS
//   sys_clock    in   1           single clock; all state changes on rising edge
//   reset        in   1           synchronous, active-high
//   req_valid    in   1           request present
//   req_ready    out  1           block can accept a request this cycle
//   req_write    in   1           1 = write, 0 = read
//   req_addr     in   ADDR_WIDTH  request address
//   req_wdata    in   DATA_WIDTH  write data
//   rsp_valid    out  1           one-cycle pulse: access complete
//   rsp_rdata    out  DATA_WIDTH  read data; held until the next read completes
//   busy         out  1           access in progress (state != IDLE)
//   mem_addr     out  ADDR_WIDTH  SRAM address, registered
//   mem_wdata    out  DATA_WIDTH  SRAM write data, registered
//   mem_data_oe  out  1           1 = drive mem_wdata onto the SRAM data bus
//   mem_rdata    in   DATA_WIDTH  SRAM data bus input
//   mem_ce_n     out  1           chip enable, active low
//   mem_oe_n     out  1           output enable, active low
//   mem_we_n     out  1           write enable, active low
// BEHAVIOUR
//   - FSM states: IDLE, SETUP, STROBE, HOLD. One down-counter is sized for max(SETUP_CYCLES, WAIT_STATES).
//   - Reset (sampled at an edge):
//     - Forces IDLE.
//     - mem_ce_n/oe_n/we_n = 1; mem_data_oe = 0; mem_addr = mem_wdata = 0.
//     - rsp_valid = 0, rsp_rdata = 0.
//   - req_ready = (state == IDLE) & ~reset.
//   - Accept occurs when req_valid & req_ready at an edge.
//     - That edge latches addr, wdata and write into mem_addr/mem_wdata and an internal write flag.
//     - The FSM enters SETUP.
//   - Timing relative to the accept cycle 0:
//     - SETUP: cycles 1..S.
//     - STROBE: cycles S+1..S+W.
//     - HOLD: cycle S+W+1.
//     - IDLE (req_ready = 1 again): cycle S+W+2.
//     - Here S = SETUP_CYCLES and W = WAIT_STATES.
//   - mem_ce_n = 0 in SETUP, STROBE and HOLD. mem_addr is stable over that whole window.
//   - Write access:
//     - mem_data_oe = 1 in SETUP..HOLD.
//     - mem_we_n = 0 only in STROBE; it rises at the entry to HOLD, so data hold is 1 cycle.
//     - mem_oe_n stays 1.
//   - Read access:
//     - mem_oe_n = 0 in SETUP..STROBE.
//     - mem_data_oe stays 0 and mem_we_n stays 1.
//     - rsp_rdata <= mem_rdata at the edge ending the last STROBE cycle.
//   - rsp_valid = 1 during HOLD only, for both reads and writes.
//     - A write leaves rsp_rdata unchanged.
//   - All mem_* outputs are flops: no combinational path from req_* to mem_*.
//   - req_* inputs are ignored outside IDLE.
//   - Back-to-back accesses: one access per S+W+2 cycles. There is no overlap.
//   - Reset asserted mid-access:
//     - Strobes deassert at that edge.
//     - No rsp_valid is produced for the aborted access.
//     - The next accept is possible in the first cycle after reset is removed.
//   - Illegal parameter values (SETUP_CYCLES or WAIT_STATES < 1) fail elaboration via generate-time check.
// TESTING
//   1. Defaults; write addr 16'h1234, data 8'hA5 at cycle 0.
//      Required: ce_n low cycles 1-4; we_n low cycles 2-3 only; data_oe high 1-4;
//      rsp_valid cycle 4 only; req_ready high cycle 5.
//   2. Read addr 16'h1234 with model SRAM returning 8'hA5.
//      Required: oe_n low cycles 1-3; rsp_rdata = 8'hA5 with rsp_valid in cycle 4; we_n never low.
//   3. req_valid held high for 3 requests.
//      Required: accepts at cycles 0, 5, 10; exactly 3 rsp_valid pulses (cycles 4, 9, 14).
//   4. reset asserted in cycle 2 of a write.
//      Required: at the following edge all strobes are inactive; no rsp_valid; state IDLE;
//      a new read completes normally after release.
//   5. SETUP_CYCLES=2, WAIT_STATES=1; write then read.
//      Required: we_n low cycle 3 only; rsp_valid cycle 4; read data sampled at the end of cycle 3.
//   6. Write 8'h5A, then read with mem_rdata changing during HOLD.
//      Required: rsp_rdata keeps the STROBE-end sample; rsp_rdata unchanged across the write.

Source files
------------

// File: rtl/k12a_sram_seq.sv
// Asynchronous SRAM access sequencer: one request at a time, registered strobes,
// programmable setup and strobe lengths, one-cycle response pulse.
module k12a_sram_seq #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int WAIT_STATES  = 2
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_data_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n
);

  localparam int MAX_CYC = (SETUP_CYCLES > WAIT_STATES) ? SETUP_CYCLES : WAIT_STATES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_STATES - 1);

  generate
    if (SETUP_CYCLES < 1 || WAIT_STATES < 1) begin : g_param_check
      $error("k12a_sram_seq: SETUP_CYCLES and WAIT_STATES must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wr, wr_nxt;
  logic             accept;

  assign req_ready = (state == IDLE) & ~reset;
  assign accept    = req_valid & req_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = wr;
    case (state)
      IDLE: if (accept) begin
        state_nxt = SETUP;
        cnt_nxt   = SETUP_LOAD;
        wr_nxt    = req_write;
      end
      SETUP: if (cnt == '0) begin
        state_nxt = STROBE;
        cnt_nxt   = WAIT_LOAD;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
      STROBE: if (cnt == '0) state_nxt = HOLD;
              else           cnt_nxt   = cnt - CNT_W'(1);
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change exactly on state entry.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr          <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_ce_n    <= 1'b1;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_data_oe <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wr          <= wr_nxt;
      if (accept) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
      mem_ce_n    <= (state_nxt == IDLE);
      mem_oe_n    <= ~(~wr_nxt & ((state_nxt == SETUP) | (state_nxt == STROBE)));
      mem_we_n    <= ~(wr_nxt & (state_nxt == STROBE));
      mem_data_oe <= wr_nxt & (state_nxt != IDLE);
      rsp_valid   <= (state_nxt == HOLD);
      if (state == STROBE && cnt == '0 && !wr)
        rsp_rdata <= mem_rdata;
    end
  end

endmodule
